// File: rtl/id_issue_queue.sv
// id_issue_queue: in-order decode-to-issue buffer.
// Registered head/count, prev-issued register, no issue->decode ack path.
module id_issue_queue #(
  parameter int unsigned NrIssuePorts = 2,
  parameter type scoreboard_entry_t = logic,
  parameter int unsigned DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic flush_i,
  input  scoreboard_entry_t [NrIssuePorts-1:0] decoded_instr_i,
  input  logic [NrIssuePorts-1:0][31:0] orig_instr_i,
  input  logic [NrIssuePorts-1:0] is_ctrl_flow_i,
  input  logic [NrIssuePorts-1:0] decoded_instr_valid_i,
  output logic [NrIssuePorts-1:0] decoded_instr_ack_o,
  output scoreboard_entry_t [NrIssuePorts-1:0] issue_instr_o,
  output logic [NrIssuePorts-1:0][31:0] issue_orig_instr_o,
  output logic [NrIssuePorts-1:0] issue_instr_valid_o,
  input  logic [NrIssuePorts-1:0] issue_ack_i,
  output scoreboard_entry_t issue_instr_prev_o,
  output logic issue_prev_valid_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic full_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  scoreboard_entry_t mem_entry [DEPTH];
  logic [31:0] mem_orig [DEPTH];
  logic mem_ctrl [DEPTH];

  logic [PW-1:0] rptr_q, wptr_q;
  logic [CW-1:0] count_q;
  scoreboard_entry_t prev_q, prev_d;
  logic prev_valid_q;

  logic [NrIssuePorts-1:0] ack, deq, vld;
  logic [CW-1:0] n_enq, n_deq;
  logic chain_e, chain_d;
  logic [PW-1:0] idx;

  // Enqueue acks from registered space only; ports accepted as a prefix.
  always_comb begin
    ack = '0;
    n_enq = '0;
    chain_e = !rst_i && !flush_i;
    for (int k = 0; k < NrIssuePorts; k++) begin
      ack[k] = chain_e && decoded_instr_valid_i[k]
               && (count_q <= CW'(DEPTH - 1 - k));
      chain_e = ack[k];
      if (ack[k]) n_enq = n_enq + CW'(1);
    end
  end

  // Head presentation, consume chain and youngest-consumed selection.
  always_comb begin
    vld = '0;
    deq = '0;
    n_deq = '0;
    idx = rptr_q;
    prev_d = prev_q;
    issue_instr_o = '0;
    issue_orig_instr_o = '0;
    chain_d = !flush_i;
    for (int k = 0; k < NrIssuePorts; k++) begin
      idx = rptr_q + PW'(k);
      vld[k] = (count_q > CW'(k)) && (k == 0 || !mem_ctrl[rptr_q]);
      if (vld[k]) begin
        issue_instr_o[k] = mem_entry[idx];
        issue_orig_instr_o[k] = mem_orig[idx];
      end
      deq[k] = chain_d && vld[k] && issue_ack_i[k];
      chain_d = deq[k];
      if (deq[k]) begin
        n_deq = n_deq + CW'(1);
        prev_d = mem_entry[idx];
      end
    end
  end

  // Pointers, occupancy and previous-instruction register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rptr_q <= '0;
      wptr_q <= '0;
      count_q <= '0;
      prev_q <= '0;
      prev_valid_q <= 1'b0;
    end else if (flush_i) begin
      rptr_q <= '0;
      wptr_q <= '0;
      count_q <= '0;
      prev_valid_q <= 1'b0;
    end else begin
      wptr_q <= wptr_q + PW'(n_enq);
      rptr_q <= rptr_q + PW'(n_deq);
      count_q <= count_q + n_enq - n_deq;
      if (deq[0]) begin
        prev_q <= prev_d;
        prev_valid_q <= 1'b1;
      end
    end
  end

  // Storage writes; acks are already gated by reset and flush.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NrIssuePorts; k++) begin
      if (ack[k]) begin
        mem_entry[wptr_q + PW'(k)] <= decoded_instr_i[k];
        mem_orig[wptr_q + PW'(k)] <= orig_instr_i[k];
        mem_ctrl[wptr_q + PW'(k)] <= is_ctrl_flow_i[k];
      end
    end
  end

  assign decoded_instr_ack_o = ack;
  assign issue_instr_valid_o = vld;
  assign issue_instr_prev_o = prev_q;
  assign issue_prev_valid_o = prev_valid_q;
  assign count_o = count_q;
  assign full_o = (count_q == CW'(DEPTH));

endmodule

// File: tb/tb_id_issue_queue.sv
// tb_id_issue_queue: directed bench for id_issue_queue.
// Two ports, depth 4, 8-bit entries.
module tb_id_issue_queue;

  logic clk = 1'b0;
  logic rst, flush;
  logic [1:0][7:0] dec;
  logic [1:0][31:0] orig;
  logic [1:0] ctrl, dv, dack, ivalid, iack;
  logic [1:0][7:0] iinstr;
  logic [1:0][31:0] iorig;
  logic [7:0] prev;
  logic prev_v, full;
  logic [2:0] cnt;
  logic [7:0] e0, e1;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  id_issue_queue #(
    .NrIssuePorts(2),
    .scoreboard_entry_t(logic [7:0]),
    .DEPTH(4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .flush_i(flush),
    .decoded_instr_i(dec),
    .orig_instr_i(orig),
    .is_ctrl_flow_i(ctrl),
    .decoded_instr_valid_i(dv),
    .decoded_instr_ack_o(dack),
    .issue_instr_o(iinstr),
    .issue_orig_instr_o(iorig),
    .issue_instr_valid_o(ivalid),
    .issue_ack_i(iack),
    .issue_instr_prev_o(prev),
    .issue_prev_valid_o(prev_v),
    .count_o(cnt),
    .full_o(full)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic offer(input logic [1:0] v, input logic [7:0] a,
                       input logic [7:0] b, input logic [1:0] c);
    dv = v;
    dec[0] = a;
    dec[1] = b;
    orig[0] = {24'hC0DE00, a};
    orig[1] = {24'hC0DE00, b};
    ctrl = c;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    iack = 2'b00;
    offer(2'b11, 8'h01, 8'h02, 2'b00);
    #1;
    repeat (3) begin
      tick;
      check("rst_ack", 64'(dack), 64'h0);
      check("rst_cnt", 64'(cnt), 64'h0);
    end
    check("rst_vld", 64'(ivalid), 64'h0);
    check("rst_pv", 64'(prev_v), 64'h0);
    rst = 1'b0;
    #1;
    check("post_rst_ack", 64'(dack), 64'h3);
    tick;
    offer(2'b00, 8'h00, 8'h00, 2'b00);
    #1;
    check("post_rst_cnt", 64'(cnt), 64'h2);
    check("post_rst_vld", 64'(ivalid), 64'h3);
    check("post_rst_i0", 64'(iinstr[0]), 64'h01);
    check("post_rst_i1", 64'(iinstr[1]), 64'h02);
    check("post_rst_o1", 64'(iorig[1]), 64'hC0DE0002);

    iack = 2'b10;
    tick;
    check("illack_cnt", 64'(cnt), 64'h2);
    check("illack_pv", 64'(prev_v), 64'h0);
    iack = 2'b00;

    offer(2'b01, 8'h03, 8'h00, 2'b00);
    #1;
    check("q3_ack", 64'(dack), 64'h1);
    tick;
    check("q3_cnt", 64'(cnt), 64'h3);
    flush = 1'b1;
    offer(2'b11, 8'h04, 8'h05, 2'b00);
    iack = 2'b01;
    #1;
    check("flush_ack", 64'(dack), 64'h0);
    tick;
    flush = 1'b0;
    iack = 2'b00;
    offer(2'b00, 8'h00, 8'h00, 2'b00);
    #1;
    check("flush_cnt", 64'(cnt), 64'h0);
    check("flush_pv", 64'(prev_v), 64'h0);
    check("flush_vld", 64'(ivalid), 64'h0);
    check("flush_prev", 64'(prev), 64'h0);

    offer(2'b11, 8'hA0, 8'hA1, 2'b00);
    #1;
    check("fill_ack0", 64'(dack), 64'h3);
    tick;
    offer(2'b11, 8'hA2, 8'hA3, 2'b00);
    #1;
    check("fill_ack1", 64'(dack), 64'h3);
    check("fill_nfull", 64'(full), 64'h0);
    tick;
    check("fill_full", 64'(full), 64'h1);
    check("fill_cnt", 64'(cnt), 64'h4);
    offer(2'b11, 8'hA4, 8'hA5, 2'b00);
    #1;
    check("fill_ack2", 64'(dack), 64'h0);
    tick;
    check("fill_cnt2", 64'(cnt), 64'h4);
    iack = 2'b01;
    #1;
    check("full_deq_ack", 64'(dack), 64'h0);
    tick;
    check("full_deq_cnt", 64'(cnt), 64'h3);
    check("full_deq_prev", 64'(prev), 64'hA0);
    check("full_deq_pv", 64'(prev_v), 64'h1);
    check("full_deq_head", 64'(iinstr[0]), 64'hA1);
    check("e_ack", 64'(dack), 64'h1);
    iack = 2'b00;
    tick;
    offer(2'b00, 8'h00, 8'h00, 2'b00);
    check("e_cnt", 64'(cnt), 64'h4);
    check("e_full", 64'(full), 64'h1);
    iack = 2'b11;
    #1;
    check("drain_vld", 64'(ivalid), 64'h3);
    tick;
    check("drain_cnt", 64'(cnt), 64'h2);
    check("drain_prev", 64'(prev), 64'hA2);
    check("drain_i0", 64'(iinstr[0]), 64'hA3);
    check("drain_i1", 64'(iinstr[1]), 64'hA4);
    tick;
    check("drain_cnt2", 64'(cnt), 64'h0);
    check("drain_prev2", 64'(prev), 64'hA4);

    for (int i = 0; i <= 20; i++) begin
      if (i < 20) begin
        e0 = 8'(8'h40 + 2 * i);
        e1 = 8'(8'h41 + 2 * i);
        offer(2'b11, e0, e1, 2'b00);
      end else begin
        offer(2'b00, 8'h00, 8'h00, 2'b00);
      end
      iack = 2'b11;
      #1;
      if (i < 20) check("strm_ack", 64'(dack), 64'h3);
      if (i >= 1) begin
        check("strm_i0", 64'(iinstr[0]), 64'(8'h40 + 2 * (i - 1)));
        check("strm_i1", 64'(iinstr[1]), 64'(8'h41 + 2 * (i - 1)));
      end
      if (i >= 2)
        check("strm_prev", 64'(prev), 64'(8'h41 + 2 * (i - 2)));
      tick;
    end
    check("strm_cnt", 64'(cnt), 64'h0);
    check("strm_prev_end", 64'(prev), 64'h67);
    iack = 2'b00;

    offer(2'b11, 8'hB0, 8'hB1, 2'b01);
    #1;
    check("cf_ack", 64'(dack), 64'h3);
    tick;
    offer(2'b00, 8'h00, 8'h00, 2'b00);
    iack = 2'b11;
    #1;
    check("cf_vld", 64'(ivalid), 64'h1);
    check("cf_head", 64'(iinstr[0]), 64'hB0);
    tick;
    check("cf_cnt", 64'(cnt), 64'h1);
    check("cf_prev", 64'(prev), 64'hB0);
    check("cf_vld2", 64'(ivalid), 64'h1);
    check("cf_head2", 64'(iinstr[0]), 64'hB1);
    tick;
    check("cf_cnt2", 64'(cnt), 64'h0);
    check("cf_prev2", 64'(prev), 64'hB1);
    check("cf_vld3", 64'(ivalid), 64'h0);
    tick;
    check("stray_cnt", 64'(cnt), 64'h0);
    check("stray_prev", 64'(prev), 64'hB1);
    iack = 2'b00;

    offer(2'b11, 8'hC0, 8'hC1, 2'b00);
    tick;
    offer(2'b00, 8'h00, 8'h00, 2'b00);
    check("mr_cnt", 64'(cnt), 64'h2);
    #3;
    rst = 1'b1;
    offer(2'b11, 8'hC2, 8'hC3, 2'b00);
    #1;
    check("mr_cnt0", 64'(cnt), 64'h0);
    check("mr_vld", 64'(ivalid), 64'h0);
    check("mr_i0", 64'(iinstr[0]), 64'h0);
    check("mr_pv", 64'(prev_v), 64'h0);
    check("mr_prev", 64'(prev), 64'h0);
    check("mr_ack", 64'(dack), 64'h0);
    tick;
    rst = 1'b0;
    offer(2'b00, 8'h00, 8'h00, 2'b00);
    tick;
    check("mr_after", 64'(cnt), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
